mult_div_unit: RTL and testbench

//  Multicycle signed multiply/divide unit of the datapath. Computes a*b or a/b iteratively.

---
 rtl/mult_div_unit.sv | 193 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit with HI/LO result registers.
// Optional macro DIV_ZERO_EXC_EN: early divide-by-zero exit with a div_zero pulse.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
`ifdef DIV_ZERO_EXC_EN
    ,
    output logic             div_zero
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, next_state;

    // Working registers: acc is one bit wider so Booth add/sub and the restoring trial never overflow
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qreg;
    logic [WIDTH-1:0] mcand;
    logic             q_m1;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic             last_iter;

    logic             busy_next;
    logic             done_next;
`ifdef DIV_ZERO_EXC_EN
    logic             dz;
    logic             div_zero_next;
`endif

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Datapath helpers for one Booth step and one restoring-division step
    always_comb begin
        a_abs     = a[WIDTH-1] ? WIDTH'(-a) : a;
        b_abs     = b[WIDTH-1] ? WIDTH'(-b) : b;
        m_ext     = {mcand[WIDTH-1], mcand};
        booth_sum = acc;
        case ({qreg[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        shifted   = {acc[WIDTH-1:0], qreg[WIDTH-1]};
        trial     = shifted - {1'b0, mcand};
        last_iter = (cnt == CNT_W'(WIDTH));
    end

    // Next-state and registered-output decode
    always_comb begin
        next_state = state;
        busy_next  = 1'b0;
        done_next  = 1'b0;
`ifdef DIV_ZERO_EXC_EN
        div_zero_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_mult)     next_state = MULT;
                else if (start_div) next_state = DIV;
            end
            MULT: if (last_iter) next_state = DONE;
            DIV: begin
`ifdef DIV_ZERO_EXC_EN
                if (dz) begin
                    next_state    = DONE;
                    div_zero_next = 1'b1;
                end else if (last_iter) begin
                    next_state = DONE;
                end
`else
                if (last_iter) next_state = DONE;
`endif
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        busy_next = (next_state == MULT) || (next_state == DIV);
        done_next = (next_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
            div_zero <= 1'b0;
`endif
        end else begin
            state <= next_state;
            busy  <= busy_next;
            done  <= done_next;
`ifdef DIV_ZERO_EXC_EN
            div_zero <= div_zero_next;
`endif
        end
    end

    // Operand capture, iteration and final HI/LO write
    always_ff @(posedge clk) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            acc   <= '0;
            qreg  <= '0;
            mcand <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
            dz    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    acc <= '0;
                    q_m1 <= 1'b0;
                    if (start_mult) begin
                        qreg  <= b;
                        mcand <= a;
                    end else if (start_div) begin
                        qreg  <= a_abs;
                        mcand <= b_abs;
                        // A zero divisor leaves the all-ones quotient unsigned
                        neg_q <= (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
                        neg_r <= a[WIDTH-1];
`ifdef DIV_ZERO_EXC_EN
                        dz    <= (b == '0);
`endif
                    end
                end
                MULT: begin
                    if (!last_iter) begin
                        {acc, qreg, q_m1} <= {booth_sum[WIDTH], booth_sum, qreg};
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        hi <= acc[WIDTH-1:0];
                        lo <= qreg;
                    end
                end
                DIV: begin
`ifdef DIV_ZERO_EXC_EN
                    if (dz) begin
                        cnt <= cnt;
                    end else
`endif
                    if (!last_iter) begin
                        if (!trial[WIDTH]) begin
                            acc  <= trial;
                            qreg <= {qreg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc  <= shifted;
                            qreg <= {qreg[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        lo <= neg_q ? WIDTH'(-qreg) : qreg;
                        hi <= neg_r ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO, a monitor pops on done.
module tb_mult_div_unit;

    localparam int unsigned WIDTH = 32;
`ifdef DIV_ZERO_EXC_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = WIDTH + 1;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             dz;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
`ifdef DIV_ZERO_EXC_EN
    logic             div_zero;
`endif

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done)
`ifdef DIV_ZERO_EXC_EN
        ,
        .div_zero   (div_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
`ifdef DIV_ZERO_EXC_EN
                check("div_zero", 32'(div_zero), 32'(e.dz));
`endif
            end
        end
    end

    // Issue one op, optionally poke an ignored start mid-flight, and check busy/done timing
    task automatic run_op(input string name, input logic do_mult, input logic do_div,
                          input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo,
                          input logic exp_dz, input int lat, input logic inject);
        int k;
        int busy_cnt;
        exp_t e;
        @(negedge clk);
        start_mult = do_mult;
        start_div  = do_div;
        a = op_a;
        b = op_b;
        e.hi = exp_hi;
        e.lo = exp_lo;
        e.dz = exp_dz;
        exp_q.push_back(e);
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        k = 0;
        busy_cnt = 0;
        while (!done && k < 100) begin
            if (busy) busy_cnt++;
            if (inject && k == 10) begin
                start_div = 1'b1;
                a = 32'd100;
                b = 32'd3;
            end else begin
                start_div = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start_div = 1'b0;
        check({name, "_latency"}, 32'(k), 32'(lat));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b0);
        run_op("mul_min_min", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 1'b1);
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
        run_op("div_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
`ifdef DIV_ZERO_EXC_EN
        run_op("div_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'h00000001, 32'hFFFFFFFD, 1'b1, DZ_LAT, 1'b0);
`else
        run_op("div_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 1'b0, DZ_LAT, 1'b0);
`endif
        run_op("div_min_m1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 1'b0);
        run_op("div_m100_7", 1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 33, 1'b0);
        run_op("both_3_4", 1'b1, 1'b1, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 1'b0, 33, 1'b0);

        // A start during the DONE cycle must be ignored
        start_mult = 1'b1;
        a = 32'd9;
        b = 32'd9;
        @(negedge clk);
        start_mult = 1'b0;
        check("done_cycle_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_cycle_start_busy2", 32'(busy), 32'd0);

        // Reset in the middle of a multiply: no result, registers cleared
        d0 = n_done;
        start_mult = 1'b1;
        a = 32'd11;
        b = 32'd13;
        @(negedge clk);
        start_mult = 1'b0;
        repeat (9) @(negedge clk);
        start_div = 1'b1;
        a = 32'd50;
        b = 32'd5;
        @(negedge clk);
        start_div = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        check("post_rst_no_done", 32'(n_done - d0), 32'd0);
        check("post_rst_busy_idle", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
